// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline types for the MEM stage: data/enable types, writeback select, LSU FSM states.
package mem_stage_lsu_pkg;

  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  localparam enable_t ENABLE  = 1'b1;
  localparam enable_t DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WB_DATA_SEL_ALU = 2'd0,
    WB_DATA_SEL_MEM = 2'd1,
    WB_DATA_SEL_PC  = 2'd2,
    WB_DATA_SEL_IMM = 2'd3
  } wb_data_sel_t;

  // Deterministic idle value driven when no load data is being returned
  localparam data_t DATA_UNKNOWN = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } lsu_state_t;

  function automatic data_t word_align(input data_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting, pulses timeout on the TIMEOUT_CYCLES-th one.
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)  cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // cnt_q holds the number of earlier wait cycles, so this fires on wait cycle number TIMEOUT_CYCLES
  assign timeout = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with req/gnt/rvalid data port, stall generation and a watchdog.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  data_t        alu_result_i,
  input  enable_t      mem_write_c_i,
  input  data_t        mem_write_data_i,
  input  wb_data_sel_t wb_data_sel_c_i,
  input  enable_t      reg_write_c_i,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output data_t        dmem_addr_o,
  output data_t        dmem_wdata_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  data_t        dmem_rdata_i,
  output data_t        mem_read_data_o,
  output enable_t      reg_write_c_o,
  output enable_t      stall_c_o,
  output logic         bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
 ,output logic         misalign_o
`endif
);

  lsu_state_t state_q, state_d;
  logic  is_store, is_load, access, misaligned, access_ok;
  logic  req_c, stall_c, abort, wd_clr, wd_en, wd_timeout;
  data_t rd_c;

  assign is_store = mem_write_c_i;
  assign is_load  = !mem_write_c_i && (wb_data_sel_c_i == WB_DATA_SEL_MEM);
  assign access   = is_store || is_load;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (state_q == IDLE) && access && (alu_result_i[1:0] != 2'b00);
  assign misalign_o = misaligned && ARESETn;
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok = access && !misaligned;

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    rd_c    = DATA_UNKNOWN;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_ok) begin
          req_c = 1'b1;
          if (is_store) begin
            if (!dmem_gnt_i) begin
              stall_c = 1'b1;
              state_d = WAIT_GNT;
            end
          end else begin
            stall_c = 1'b1;
            state_d = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req_c = 1'b1;
        if (dmem_gnt_i) begin
          if (is_store) begin
            state_d = IDLE;
          end else begin
            stall_c = 1'b1;
            state_d = WAIT_RVALID;
          end
        end else if (wd_timeout) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          rd_c    = dmem_rdata_i;
          state_d = IDLE;
        end else if (wd_timeout) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   bus_err_o <= 1'b0;
    else if (abort) bus_err_o <= 1'b1;
  end

  // Each wait state gets a fresh budget, including the WAIT_GNT -> WAIT_RVALID hop
  assign wd_en  = (state_q != IDLE);
  assign wd_clr = (state_d != IDLE) && (state_d != state_q);

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .clr    (wd_clr),
    .en     (wd_en),
    .timeout(wd_timeout)
  );

  assign dmem_req_o      = req_c && ARESETn;
  assign dmem_we_o       = req_c && is_store && ARESETn;
  assign dmem_addr_o     = word_align(alu_result_i);
  assign dmem_wdata_o    = mem_write_data_i;
  assign mem_read_data_o = rd_c;
  assign stall_c_o       = stall_c && ARESETn;
  assign reg_write_c_o   = reg_write_c_i && !abort && !misaligned && ARESETn;

endmodule
